// File: rtl/regfile_param.sv
// Parametrised single-write, dual-read register file with a post-reset clear sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to matching read ports.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              Ready,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    input  logic              WriteEnable,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    output logic              dbg_state_o
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_e            state_q;
    logic [ADDR_W-1:0] index_q;
    logic              ready_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              wr_legal;
    logic [WIDTH-1:0]  rd1_d;
    logic [WIDTH-1:0]  rd2_d;

    // An address maps to real storage only if it is in range and not the hardwired zero entry.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_EXT) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            index_q <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    index_q <= index_q + 1'b1;
                    if (index_q == LAST_IDX) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= CLEAR;
                    index_q <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_legal = ready_q && WriteEnable && addr_ok(WriteRegister);

    // Storage has no reset; the sequencer zeroes it one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[index_q] <= '0;
        end else if (wr_legal) begin
            mem_q[WriteRegister] <= WriteData;
        end
    end

    always_comb begin
        rd1_d = '0;
        if (ready_q && addr_ok(ReadRegister1)) begin
            rd1_d = mem_q[ReadRegister1];
`ifdef REGFILE_BYPASS_EN
            if (wr_legal && (WriteRegister == ReadRegister1)) begin
                rd1_d = WriteData;
            end
`endif
        end
    end

    always_comb begin
        rd2_d = '0;
        if (ready_q && addr_ok(ReadRegister2)) begin
            rd2_d = mem_q[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
            if (wr_legal && (WriteRegister == ReadRegister2)) begin
                rd2_d = WriteData;
            end
`endif
        end
    end

    assign ReadData1   = rd1_d;
    assign ReadData2   = rd2_d;
    assign Ready       = ready_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations (32/zero, 24/zero, 32/no-zero) share one stimulus
// stream and are each checked against an array-based reference model.
module tb_regfile_param;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  wr;
    logic [31:0] wd;

    logic        ready_w [3];
    logic [31:0] rd1_w [3];
    logic [31:0] rd2_w [3];
    logic        dbg_w [3];

    logic [31:0] mdl [3][32];
    bit          rdy_m [3];
    int          clr_cnt [3];

    int tests;
    int fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1)) u0 (
        .clk(clk), .reset(reset), .Ready(ready_w[0]),
        .ReadRegister1(r1), .ReadRegister2(r2),
        .ReadData1(rd1_w[0]), .ReadData2(rd2_w[0]),
        .WriteEnable(we), .WriteRegister(wr), .WriteData(wd),
        .dbg_state_o(dbg_w[0])
    );

    regfile_param #(.WIDTH(32), .DEPTH(24), .ADDR_W(5), .ZERO_REG(1)) u1 (
        .clk(clk), .reset(reset), .Ready(ready_w[1]),
        .ReadRegister1(r1), .ReadRegister2(r2),
        .ReadData1(rd1_w[1]), .ReadData2(rd2_w[1]),
        .WriteEnable(we), .WriteRegister(wr), .WriteData(wd),
        .dbg_state_o(dbg_w[1])
    );

    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(0)) u2 (
        .clk(clk), .reset(reset), .Ready(ready_w[2]),
        .ReadRegister1(r1), .ReadRegister2(r2),
        .ReadData1(rd1_w[2]), .ReadData2(rd2_w[2]),
        .WriteEnable(we), .WriteRegister(wr), .WriteData(wd),
        .dbg_state_o(dbg_w[2])
    );

    function automatic int dep_of(input int k);
        return (k == 1) ? 24 : 32;
    endfunction

    function automatic bit zero_of(input int k);
        return (k == 2) ? 1'b0 : 1'b1;
    endfunction

    function automatic bit legal(input int k, input int a);
        return (a < dep_of(k)) && !(zero_of(k) && (a == 0));
    endfunction

    function automatic logic [31:0] exp_rd(input int k, input int a);
        if (!rdy_m[k] || !legal(k, a)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && legal(k, int'(wr)) && (int'(wr) == a)) return wd;
`endif
        return mdl[k][a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d ready", k), {31'b0, ready_w[k]}, {31'b0, rdy_m[k]});
            chk($sformatf("u%0d rd1 a=%0d", k, r1), rd1_w[k], exp_rd(k, int'(r1)));
            chk($sformatf("u%0d rd2 a=%0d", k, r2), rd2_w[k], exp_rd(k, int'(r2)));
        end
    endtask

    task automatic model_edge();
        if (reset) return;
        for (int k = 0; k < 3; k++) begin
            if (rdy_m[k]) begin
                if (we && legal(k, int'(wr))) mdl[k][wr] = wd;
            end else begin
                clr_cnt[k]++;
                if (clr_cnt[k] == dep_of(k)) begin
                    rdy_m[k] = 1'b1;
                    for (int a = 0; a < 32; a++) mdl[k][a] = 32'h0;
                end
            end
        end
    endtask

    // Apply inputs, check at the falling edge, then advance the model on the rising edge.
    task automatic step(input logic e, input logic [4:0] w, input logic [31:0] d,
                        input logic [4:0] a1, input logic [4:0] a2);
        we = e; wr = w; wd = d; r1 = a1; r2 = a2;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_async();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            rdy_m[k]   = 1'b0;
            clr_cnt[k] = 0;
            chk($sformatf("u%0d async ready", k), {31'b0, ready_w[k]}, 32'h0);
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < 32; a++) begin
            step(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        we = 1'b0; wr = '0; wd = '0; r1 = '0; r2 = '0;
        for (int k = 0; k < 3; k++) begin
            rdy_m[k]   = 1'b0;
            clr_cnt[k] = 0;
            for (int a = 0; a < 32; a++) mdl[k][a] = 32'h0;
        end

        // Reset held for three cycles, then the clear sequence with a write that must be lost.
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'h0, 5'd0, 5'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i < 20) step(1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'($urandom_range(0, 31)));
            else        step(1'b0, 5'd3, 32'h0, 5'd3, 5'($urandom_range(0, 31)));
        end
        read_all();

        // Basic read/write and shared-address reads.
        step(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        step(1'b1, 5'd31, 32'h12345678, 5'd5, 5'd5);
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

        // Zero register, then out-of-range write.
        step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd1);
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        step(1'b1, 5'd27, 32'h00000055, 5'd27, 5'd23);
        read_all();

        // Same-cycle write/read hazard on r7.
        step(1'b1, 5'd7, 32'h11110007, 5'd1, 5'd2);
        step(1'b1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd7);
        step(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

        // Randomized traffic, biased toward same-address hazards.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] w;
            logic [4:0] a1;
            w  = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), w, $urandom, a1, 5'($urandom_range(0, 31)));
        end
        read_all();

        // Reset re-asserted mid-clear; clear must restart from scratch.
        reset_async();
        step(1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd5);
        reset_async();
        step(1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd5);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i < 22) step(1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd5);
            else        step(1'b0, 5'd3, 32'h0, 5'd3, 5'd5);
        end
        read_all();

        // Reset while running drops Ready immediately.
        step(1'b1, 5'd9, 32'h0BADCAFE, 5'd9, 5'd9);
        reset_async();
        step(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        reset = 1'b0;
        for (int i = 0; i < 34; i++) step(1'b0, 5'd0, 32'h0, 5'd9, 5'($urandom_range(0, 31)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the single-write, dual-read CPU register file.
- Configurable data width and depth, optional hardwired zero register, out-of-range address protection.
- Hardware clear sequencer zeroes every entry after reset; Ready handshake tells the core when the file is usable.
- Sits in the decode/writeback stage of the Turboencabulator core.

Parameters:
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers (2..2**ADDR_W)
- ADDR_W, 5, address bits
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- Ready  output  1  high when clear sequence is done and writes are accepted
- ReadRegister1  input  ADDR_W  read port 1 address
- ReadRegister2  input  ADDR_W  read port 2 address
- ReadData1  output  WIDTH  read port 1 data, combinational
- ReadData2  output  WIDTH  read port 2 data, combinational
- WriteEnable  input  1  write strobe
- WriteRegister  input  ADDR_W  write address
- WriteData  input  WIDTH  write data

Behaviour:
- States: CLEAR, RUN. Clear index counter is ADDR_W bits.
- Reset asserted (async): state=CLEAR, index=0, Ready=0 immediately. Storage contents are don't-care.
- CLEAR, each rising clk with reset low: writes 0 to entry[index], then index+1.
  - At index==DEPTH-1, that entry is cleared, state goes to RUN and Ready=1 from the same edge.
  - Ready therefore rises on the DEPTH-th rising edge after reset deassertion.
- Reset re-asserted mid-CLEAR or in RUN: returns to CLEAR at index 0; the full sequence restarts.
- While Ready=0:
  - WriteEnable is ignored.
  - ReadData1/ReadData2 are forced to 0.
- RUN write: on rising edge with WriteEnable=1, entry[WriteRegister] <= WriteData.
  - The write is ignored if WriteRegister >= DEPTH.
  - The write is ignored if ZERO_REG=1 and WriteRegister==0.
- RUN read: ReadDataN = entry[ReadRegisterN], combinational, independent per port. Both ports may use the same address.
  - Returns 0 if ReadRegisterN >= DEPTH.
  - Returns 0 if ZERO_REG=1 and address==0.
- Write-then-read latency: data written at edge k is visible on both read ports after edge k, i.e. in cycle k+1.
- Same-cycle write/read to the same address: see Optional Feature.
- No X may reach ReadData1/2 after Ready=1 for any in-range or out-of-range address.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-through forwarding. In RUN, if WriteEnable=1, the write is legal (in range, not zero reg) and ReadRegisterN==WriteRegister, then ReadDataN=WriteData combinationally in the same cycle.
  - Both ports bypass independently.
- Undefined: a same-cycle read returns the old stored value; the new value appears the next cycle.

Test Plan:
- Clear sequence, DEPTH=32: assert reset 3 cycles, release. Ready=0 for edges 1..31, Ready=1 after edge 32. Read every address in RUN -> 0x00000000.
- Basic RW: write 0xDEADBEEF to r5, 0x12345678 to r31. Next cycle, ReadRegister1=5 and ReadRegister2=31 -> 0xDEADBEEF, 0x12345678. Both ports at 5 -> 0xDEADBEEF on both.
- Zero reg: write 0xFFFFFFFF to r0 -> read r0 = 0. With ZERO_REG=0, same write -> read r0 = 0xFFFFFFFF.
- Reset mid-clear: release reset, re-assert after 10 edges, release again. Ready stays 0 and rises exactly 32 edges after the second release. A write of 0xAAAA5555 to r3 issued during CLEAR is lost; r3 reads 0 in RUN.
- Out of range, DEPTH=24: write 0x55 to r27 -> no entry changes; read r27 = 0; r0..r23 unchanged.
- Same-cycle hazard: write 0xCAFEF00D to r7 while reading r7. With REGFILE_BYPASS_EN, ReadData1 = 0xCAFEF00D that cycle. Without it, ReadData1 = previous value that cycle and 0xCAFEF00D the next cycle.
